// File: rtl/lock_pkg.sv
// Shared definitions for the lock sequencer: FSM state encoding, transit
// direction constants and default timing/width parameters.
package lock_pkg;

    localparam int LVL_W_DEF        = 4;
    localparam int OPEN_TIMEOUT_DEF = 16;
    localparam int CLOSE_TICKS_DEF  = 2;
    localparam int EQ_MAX_DEF       = 20;

    // Transit direction: arrival->departure or departure->arrival.
    localparam logic DIR_AD = 1'b0;
    localparam logic DIR_DA = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EQ_IN,
        ST_OPEN_IN,
        ST_CLOSE_IN,
        ST_EQ_OUT,
        ST_OPEN_OUT,
        ST_CLOSE_OUT,
        ST_FAULT
    } lock_state_t;

endpackage

// File: rtl/lock_sequencer_if.sv
// Bundle of the sequencer's plant-side signals.
//   slave  : the sequencer (takes requests, levels, boat pulses; drives commands)
//   master : the environment (drives tick, requests, levels, boat pulses)
interface lock_sequencer_if
    import lock_pkg::*;
#(
    parameter int LVL_W = LVL_W_DEF
);

    logic             tick;
    logic             req_a;
    logic             req_d;
    logic             boat_in;
    logic             boat_out;
    logic [LVL_W-1:0] lvl_a;
    logic [LVL_W-1:0] lvl_d;
    logic [LVL_W-1:0] lvl_in;
    logic             gate_a;
    logic             gate_d;
    logic             fill;
    logic             drain;
    logic             occupied;
    logic             dir;
    logic             busy;
    logic             fault;

    modport slave (
        input  tick, req_a, req_d, boat_in, boat_out, lvl_a, lvl_d, lvl_in,
        output gate_a, gate_d, fill, drain, occupied, dir, busy, fault
    );

    modport master (
        output tick, req_a, req_d, boat_in, boat_out, lvl_a, lvl_d, lvl_in,
        input  gate_a, gate_d, fill, drain, occupied, dir, busy, fault
    );

endinterface

// File: rtl/tick_timer.sv
// Loadable down-counter advanced only on tick.
//   clk, reset : clock, async active-high reset
//   tick       : timebase strobe
//   load       : reload count with load_val (takes priority over tick)
//   load_val   : number of ticks in the period
//   done       : high on the tick that completes the period
module tick_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    // Flag the expiring tick itself so the FSM moves on that same edge.
    assign done = tick && (count <= CNT_W'(1));

endmodule

// File: rtl/lock_sequencer.sv
// Canal lock transit sequencer: grants one side, equalizes the chamber,
// opens/closes gates around the boat and raises a sticky fault on timeout
// or command conflict. All outputs are registered.
//   clk, reset : clock, async active-high reset
//   bus        : plant-side signals (lock_sequencer_if.slave)
//
// state     | meaning
// IDLE      | waiting for a request
// EQ_IN     | equalize chamber to entry side
// OPEN_IN   | entry gate open, waiting for boat_in (timeout -> abort)
// CLOSE_IN  | gates closed settle after entry
// EQ_OUT    | equalize chamber to exit side
// OPEN_OUT  | exit gate open, waiting for boat_out
// CLOSE_OUT | gates closed settle after exit
// FAULT     | everything off, only reset leaves
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int LVL_W        = LVL_W_DEF,
    parameter int OPEN_TIMEOUT = OPEN_TIMEOUT_DEF,
    parameter int CLOSE_TICKS  = CLOSE_TICKS_DEF,
    parameter int EQ_MAX       = EQ_MAX_DEF
) (
    input logic              clk,
    input logic              reset,
    lock_sequencer_if.slave  bus
);

    localparam int MAX_T = (EQ_MAX > OPEN_TIMEOUT) ?
                           ((EQ_MAX > CLOSE_TICKS) ? EQ_MAX : CLOSE_TICKS) :
                           ((OPEN_TIMEOUT > CLOSE_TICKS) ? OPEN_TIMEOUT : CLOSE_TICKS);
    localparam int TM_W = $clog2(MAX_T + 1);

    lock_state_t      state, state_nxt;
    logic             dir_q, dir_nxt;
    logic             occ_q, occ_nxt;
    logic             abort_q, abort_nxt;
    logic             last_q, last_nxt;
    logic             gate_a_q, gate_a_nxt;
    logic             gate_d_q, gate_d_nxt;
    logic             fill_q, fill_nxt;
    logic             drain_q, drain_nxt;
    logic             busy_q, fault_q;
    logic [LVL_W-1:0] tgt_cur, tgt_nxt;
    logic             in_eq_nxt;
    logic             tm_load, tm_done;
    logic [TM_W-1:0]  tm_val;

    tick_timer #(.CNT_W(TM_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .tick     (bus.tick),
        .load     (tm_load),
        .load_val (tm_val),
        .done     (tm_done)
    );

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir_q;
        occ_nxt   = occ_q;
        abort_nxt = abort_q;
        last_nxt  = last_q;
        // Arrival level is the target when equalizing to the entry side of an
        // arrival transit or the exit side of a departure transit.
        tgt_cur = ((state == ST_EQ_IN) ^ dir_q) ? bus.lvl_a : bus.lvl_d;

        case (state)
            ST_IDLE: begin
                if (bus.req_a || bus.req_d) begin
                    state_nxt = ST_EQ_IN;
                    abort_nxt = 1'b0;
                    if (bus.req_a && bus.req_d) begin
                        dir_nxt = (last_q == DIR_AD) ? DIR_DA : DIR_AD;
                    end else begin
                        dir_nxt = bus.req_d ? DIR_DA : DIR_AD;
                    end
                end
            end
            ST_EQ_IN: begin
                if (bus.lvl_in == tgt_cur) state_nxt = ST_OPEN_IN;
                else if (tm_done)          state_nxt = ST_FAULT;
            end
            ST_OPEN_IN: begin
                // A boat arriving on the expiring tick still counts as entry.
                if (bus.boat_in) begin
                    occ_nxt   = 1'b1;
                    state_nxt = ST_CLOSE_IN;
                end else if (tm_done) begin
                    abort_nxt = 1'b1;
                    state_nxt = ST_CLOSE_IN;
                end
            end
            ST_CLOSE_IN: begin
                if (tm_done) state_nxt = abort_q ? ST_IDLE : ST_EQ_OUT;
            end
            ST_EQ_OUT: begin
                if (bus.lvl_in == tgt_cur) state_nxt = ST_OPEN_OUT;
                else if (tm_done)          state_nxt = ST_FAULT;
            end
            ST_OPEN_OUT: begin
                if (bus.boat_out) begin
                    occ_nxt   = 1'b0;
                    state_nxt = ST_CLOSE_OUT;
                end
            end
            ST_CLOSE_OUT: begin
                if (tm_done) begin
                    state_nxt = ST_IDLE;
                    last_nxt  = dir_q;
                end
            end
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_FAULT;
        endcase

        tgt_nxt    = ((state_nxt == ST_EQ_IN) ^ dir_nxt) ? bus.lvl_a : bus.lvl_d;
        in_eq_nxt  = (state_nxt == ST_EQ_IN) || (state_nxt == ST_EQ_OUT);
        gate_a_nxt = ((state_nxt == ST_OPEN_IN)  && (dir_nxt == DIR_AD)) ||
                     ((state_nxt == ST_OPEN_OUT) && (dir_nxt == DIR_DA));
        gate_d_nxt = ((state_nxt == ST_OPEN_IN)  && (dir_nxt == DIR_DA)) ||
                     ((state_nxt == ST_OPEN_OUT) && (dir_nxt == DIR_AD));
        fill_nxt   = in_eq_nxt && (bus.lvl_in < tgt_nxt);
        drain_nxt  = in_eq_nxt && (bus.lvl_in > tgt_nxt);

        // Safety net: any conflicting command set diverts to FAULT.
        if ((gate_a_nxt && gate_d_nxt) || (fill_nxt && drain_nxt) ||
            ((fill_nxt || drain_nxt) && (gate_a_nxt || gate_d_nxt))) begin
            state_nxt = ST_FAULT;
        end
        if (state_nxt == ST_FAULT) begin
            gate_a_nxt = 1'b0;
            gate_d_nxt = 1'b0;
            fill_nxt   = 1'b0;
            drain_nxt  = 1'b0;
            occ_nxt    = occ_q;
        end

        tm_load = (state_nxt != state);
        case (state_nxt)
            ST_EQ_IN, ST_EQ_OUT:       tm_val = TM_W'(EQ_MAX);
            ST_OPEN_IN:                tm_val = TM_W'(OPEN_TIMEOUT);
            ST_CLOSE_IN, ST_CLOSE_OUT: tm_val = TM_W'(CLOSE_TICKS);
            default:                   tm_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            dir_q    <= DIR_AD;
            occ_q    <= 1'b0;
            abort_q  <= 1'b0;
            last_q   <= DIR_DA;
            gate_a_q <= 1'b0;
            gate_d_q <= 1'b0;
            fill_q   <= 1'b0;
            drain_q  <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            dir_q    <= dir_nxt;
            occ_q    <= occ_nxt;
            abort_q  <= abort_nxt;
            last_q   <= last_nxt;
            gate_a_q <= gate_a_nxt;
            gate_d_q <= gate_d_nxt;
            fill_q   <= fill_nxt;
            drain_q  <= drain_nxt;
            busy_q   <= (state_nxt != ST_IDLE);
            fault_q  <= (state_nxt == ST_FAULT);
        end
    end

    assign bus.gate_a   = gate_a_q;
    assign bus.gate_d   = gate_d_q;
    assign bus.fill     = fill_q;
    assign bus.drain    = drain_q;
    assign bus.occupied = occ_q;
    assign bus.dir      = dir_q;
    assign bus.busy     = busy_q;
    assign bus.fault    = fault_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: directed transit scenarios plus a randomized run
// checked against a transaction-level model of grants and chamber occupancy.
module tb_lock_sequencer;
    import lock_pkg::*;

    localparam int LVL_W = 4;

    logic clk = 1'b0;
    logic reset;

    lock_sequencer_if #(.LVL_W(LVL_W)) bus();

    lock_sequencer #(
        .LVL_W        (LVL_W),
        .OPEN_TIMEOUT (16),
        .CLOSE_TICKS  (2),
        .EQ_MAX       (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    logic tick_ph;
    int   ticks_seen;
    int   n_fill;
    int   n_drain;
    bit   freeze;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // One clock: apply inputs, check invariants mid-cycle, then emulate the
    // chamber level counter stepping on tick with the sampled command.
    task automatic step(input logic tk, input logic bi, input logic bo);
        logic f, d, t, ga, gd;
        bus.tick     = tk;
        bus.boat_in  = bi;
        bus.boat_out = bo;
        @(negedge clk);
        f  = bus.fill;
        d  = bus.drain;
        t  = bus.tick;
        ga = bus.gate_a;
        gd = bus.gate_d;
        chk("invariants", 32'({ga & gd, f & d, (f | d) & (ga | gd)}), 0);
        @(posedge clk);
        #1;
        if (t && !freeze) begin
            if (f && !d && bus.lvl_in != '1) begin
                bus.lvl_in = bus.lvl_in + LVL_W'(1);
                n_fill++;
            end else if (d && !f && bus.lvl_in != '0) begin
                bus.lvl_in = bus.lvl_in - LVL_W'(1);
                n_drain++;
            end
        end
        bus.tick     = 1'b0;
        bus.boat_in  = 1'b0;
        bus.boat_out = 1'b0;
    endtask

    // Step with a tick on every other cycle, counting applied ticks.
    task automatic adv(input logic bi, input logic bo);
        logic t;
        t = tick_ph;
        step(t, bi, bo);
        if (t) ticks_seen++;
        tick_ph = ~tick_ph;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.tick     = 1'b0;
        bus.req_a    = 1'b0;
        bus.req_d    = 1'b0;
        bus.boat_in  = 1'b0;
        bus.boat_out = 1'b0;
        freeze       = 1'b0;
        tick_ph      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_transit();
        int n;
        n = 0;
        while (!(bus.gate_a || bus.gate_d) && n < 300) begin adv(0, 0); n++; end
        adv(1, 0);
        n = 0;
        while (!(bus.gate_a || bus.gate_d) && n < 300) begin adv(0, 0); n++; end
        adv(0, 1);
        n = 0;
        while (bus.busy && n < 300) begin adv(0, 0); n++; end
        chk("transit_done", 32'(bus.busy), 0);
    endtask

    initial begin
        int   n;
        logic occ_seen;
        logic pre_busy, pre_occ, pre_dir, pre_ga, pre_gd;
        logic ra, rd, tk, prev_tk, bi, bo;
        logic last_m, entered, exp_dir, exp_occ, entry_open, exit_open;

        bus.lvl_a  = '0;
        bus.lvl_d  = '0;
        bus.lvl_in = '0;
        do_reset();
        chk("reset_outputs", 32'({bus.gate_a, bus.gate_d, bus.fill, bus.drain,
                                  bus.occupied, bus.dir, bus.busy, bus.fault}), 0);

        // Full arrival transit with drain then fill.
        bus.lvl_a = 4'd3; bus.lvl_d = 4'd9; bus.lvl_in = 4'd7;
        step(0, 1, 0);
        chk("stray_boat_in_idle", 32'({bus.occupied, bus.busy}), 0);
        bus.req_a = 1'b1;
        step(0, 0, 0);
        bus.req_a = 1'b0;
        chk("s1_grant_dir", 32'(bus.dir), 32'(DIR_AD));
        chk("s1_drain_on", 32'({bus.fill, bus.drain}), 32'b01);
        n_drain = 0; n = 0;
        while (!bus.gate_a && n < 200) begin adv(0, 0); n++; end
        chk("s1_drain_steps", n_drain, 4);
        chk("s1_lvl_at_open", 32'(bus.lvl_in), 3);
        chk("s1_gate_a", 32'({bus.gate_a, bus.gate_d, bus.fill, bus.drain}), 32'b1000);
        adv(1, 0);
        chk("s1_occupied", 32'({bus.occupied, bus.gate_a}), 32'b10);
        ticks_seen = 0; n = 0;
        while (!bus.fill && n < 200) begin adv(0, 0); n++; end
        chk("s1_close_in_ticks", ticks_seen, 2);
        n_fill = 0; n = 0;
        while (!bus.gate_d && n < 200) begin adv(0, 0); n++; end
        chk("s1_fill_steps", n_fill, 6);
        chk("s1_lvl_at_exit", 32'(bus.lvl_in), 9);
        chk("s1_gate_d", 32'({bus.gate_a, bus.gate_d}), 32'b01);
        adv(0, 1);
        chk("s1_left", 32'({bus.occupied, bus.gate_d}), 0);
        ticks_seen = 0; n = 0;
        while (bus.busy && n < 200) begin adv(0, 0); n++; end
        chk("s1_close_out_ticks", ticks_seen, 2);
        chk("s1_idle_occ", 32'({bus.busy, bus.occupied}), 0);

        // Both sides requesting: arrival, then departure, then arrival again.
        do_reset();
        bus.lvl_a = 4'd5; bus.lvl_d = 4'd5; bus.lvl_in = 4'd5;
        bus.req_a = 1'b1; bus.req_d = 1'b1;
        step(0, 0, 0);
        chk("rr_first", 32'({bus.busy, bus.dir}), 32'b10);
        run_transit();
        step(0, 0, 0);
        chk("rr_second", 32'({bus.busy, bus.dir}), 32'b11);
        run_transit();
        step(0, 0, 0);
        chk("rr_third", 32'({bus.busy, bus.dir}), 32'b10);
        bus.req_a = 1'b0; bus.req_d = 1'b0;
        run_transit();

        // Departure request with no boat: entry gate times out.
        do_reset();
        bus.lvl_a = 4'd5; bus.lvl_d = 4'd5; bus.lvl_in = 4'd5;
        bus.req_d = 1'b1;
        step(0, 0, 0);
        bus.req_d = 1'b0;
        chk("ab_eq_state", 32'({bus.busy, bus.dir, bus.gate_d}), 32'b110);
        step(0, 0, 0);
        chk("ab_gate_open", 32'({bus.gate_a, bus.gate_d, bus.fill, bus.drain}), 32'b0100);
        ticks_seen = 0; n = 0; occ_seen = 1'b0;
        while (bus.gate_d && n < 200) begin adv(0, 0); occ_seen |= bus.occupied; n++; end
        chk("ab_open_ticks", ticks_seen, 16);
        ticks_seen = 0; n = 0;
        while (bus.busy && n < 200) begin adv(0, 0); occ_seen |= bus.occupied; n++; end
        chk("ab_close_ticks", ticks_seen, 2);
        chk("ab_never_occ", 32'(occ_seen), 0);

        // Boat entering on the very tick the entry window expires.
        do_reset();
        bus.lvl_a = 4'd5; bus.lvl_d = 4'd5; bus.lvl_in = 4'd5;
        bus.req_a = 1'b1;
        step(0, 0, 0);
        bus.req_a = 1'b0;
        step(0, 0, 0);
        ticks_seen = 0;
        while (ticks_seen < 15) adv(0, 0);
        chk("edge_gate_still_open", 32'(bus.gate_a), 1);
        if (!tick_ph) adv(0, 0);
        adv(1, 0);
        chk("edge_entry_counted", 32'({bus.occupied, bus.gate_a}), 32'b10);
        n = 0;
        while (bus.busy && !bus.gate_d && n < 200) begin adv(0, 0); n++; end
        chk("edge_no_abort", 32'({bus.busy, bus.gate_d}), 32'b11);
        adv(0, 1);
        n = 0;
        while (bus.busy && n < 200) begin adv(0, 0); n++; end

        // Level counter stuck: equalization timeout raises sticky fault.
        do_reset();
        freeze = 1'b1;
        bus.lvl_a = 4'd6; bus.lvl_d = 4'd6; bus.lvl_in = 4'd2;
        bus.req_a = 1'b1;
        step(0, 0, 0);
        bus.req_a = 1'b0;
        chk("flt_fill_on", 32'(bus.fill), 1);
        ticks_seen = 0; n = 0;
        while (!bus.fault && n < 200) begin adv(0, 0); n++; end
        chk("flt_ticks", ticks_seen, 20);
        chk("flt_outputs", 32'({bus.gate_a, bus.gate_d, bus.fill, bus.drain,
                                bus.occupied, bus.fault}), 32'b000001);
        bus.req_a = 1'b1; bus.req_d = 1'b1;
        for (int i = 0; i < 20; i++) adv(i[0], ~i[0]);
        chk("flt_sticky", 32'({bus.gate_a, bus.gate_d, bus.fill, bus.drain,
                               bus.occupied, bus.fault}), 32'b000001);
        do_reset();
        chk("flt_cleared", 32'({bus.fault, bus.busy}), 0);

        // Reset while the exit gate is open.
        bus.lvl_a = 4'd5; bus.lvl_d = 4'd5; bus.lvl_in = 4'd5;
        bus.req_a = 1'b1;
        step(0, 0, 0);
        bus.req_a = 1'b0;
        n = 0;
        while (!bus.gate_a && n < 200) begin adv(0, 0); n++; end
        adv(1, 0);
        n = 0;
        while (!bus.gate_d && n < 200) begin adv(0, 0); n++; end
        chk("rst_pre_gate_d", 32'({bus.gate_d, bus.occupied}), 32'b11);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_gates", 32'({bus.gate_a, bus.gate_d, bus.busy, bus.occupied}), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_idle_after", 32'({bus.busy, bus.gate_a, bus.gate_d, bus.fault}), 0);

        // Randomized traffic against a transit-level model.
        do_reset();
        bus.lvl_a  = LVL_W'($urandom_range(0, 15));
        bus.lvl_d  = LVL_W'($urandom_range(0, 15));
        bus.lvl_in = LVL_W'($urandom_range(0, 15));
        last_m  = DIR_DA;
        entered = 1'b0;
        prev_tk = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            pre_busy = bus.busy;
            pre_occ  = bus.occupied;
            pre_dir  = bus.dir;
            pre_ga   = bus.gate_a;
            pre_gd   = bus.gate_d;
            if (!bus.busy && $urandom_range(0, 3) == 0) begin
                bus.lvl_a = LVL_W'($urandom_range(0, 15));
                bus.lvl_d = LVL_W'($urandom_range(0, 15));
            end
            ra = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 3) == 0);
            bus.req_a = ra;
            bus.req_d = rd;
            tk = prev_tk ? 1'b0 : 1'($urandom_range(0, 1));
            prev_tk = tk;
            bi = ($urandom_range(0, 15) == 0);
            bo = ($urandom_range(0, 7) == 0);
            step(tk, bi, bo);
            if (!pre_busy) begin
                chk("rnd_grant_busy", 32'(bus.busy), 32'(ra | rd));
                if (ra || rd) begin
                    exp_dir = (ra && rd) ? ~last_m : rd;
                    chk("rnd_grant_dir", 32'(bus.dir), 32'(exp_dir));
                end
            end
            entry_open = pre_dir ? pre_gd : pre_ga;
            exit_open  = pre_dir ? pre_ga : pre_gd;
            exp_occ    = (entry_open && bi) ? 1'b1 : ((exit_open && bo) ? 1'b0 : pre_occ);
            chk("rnd_occupied", 32'(bus.occupied), 32'(exp_occ));
            if (bus.occupied) entered = 1'b1;
            if (pre_busy && !bus.busy) begin
                if (entered) last_m = pre_dir;
                entered = 1'b0;
            end
            chk("rnd_no_fault", 32'(bus.fault), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
